packet_assembler: RTL and testbench
===================================

# packet_assembler

Parametrised receive-side packet assembler for the inter-component 32-bit packet links: it collects a framed sequence of `WORDS` packet words (for example the four-word Decoder-to-ROB message or the two-word RRU-to-ROB message) into one wide message and buffers complete messages in a `DEPTH`-entry FIFO. It sits at the consumer end of a link (ROB, RRU), between the word-serial link and the consumer's dispatch logic. It also detects framing errors, which single-word packets could not express.

## Interface
- `WORD_W`, 32: link word width.
- `WORDS`, 4: words per message; must be ≥1.
- `DEPTH`, 4: FIFO entries (complete messages); must be ≥1.
- `ROB_IDX_W`, 7: width of the ROB index carried in the header word's MSBs.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  word valid.
- `in_ready`  out  1  word accepted when `in_valid & in_ready`.
- `in_sop`  in  1  marks the word as the header (first word) of a message.
- `in_word`  in  `WORD_W`  packet word.
- `out_valid`  out  1  FIFO head holds a complete message.
- `out_ready`  in  1  consumer pops the head when `out_valid & out_ready`.
- `out_msg`  out  `WORDS*WORD_W`  assembled message; header word in the MSB slot, last word in the LSB slot.
- `out_rob_index`  out  `ROB_IDX_W`  `out_msg[WORDS*WORD_W-1 -: ROB_IDX_W]`.
- `err_framing`  out  1  one-cycle pulse per framing error.
- `err_count`  out  8  framing errors since reset, saturating at 255.
- `occupancy`  out  `$clog2(DEPTH+1)`  messages currently in the FIFO.

## Operation
- Assembly FSM with two states: IDLE (no partial message) and COLLECT (word counter `cnt` from 1 to WORDS-1 words held).
- IDLE, accepted word with `in_sop=1`:
  - Store the word in slot 0.
  - If `WORDS==1`, push the message to the FIFO and stay in IDLE.
  - Otherwise set `cnt=1` and go to COLLECT.
- IDLE, accepted word with `in_sop=0`: drop the word, pulse `err_framing`, increment `err_count`.
- COLLECT, accepted word with `in_sop=0`:
  - Store the word in slot `cnt`.
  - If `cnt==WORDS-1`, push the full message to the FIFO and go to IDLE.
  - Otherwise increment `cnt`.
- COLLECT, accepted word with `in_sop=1`:
  - Discard the partial message, pulse `err_framing`, increment `err_count`.
  - Restart with this word as slot 0 (`cnt=1`, or an immediate push if `WORDS==1`).
- `in_ready = (occupancy < DEPTH)`.
  - Deasserted whenever the FIFO is full, including a cycle with a simultaneous pop (no full-bypass).
  - Accepted words never block mid-message except through this rule.
- FIFO: circular buffer with read/write pointers wrapping at `DEPTH`, for any `DEPTH`, not only powers of two.
  - Push and pop in the same cycle: occupancy unchanged, and both take effect.
  - Pop when empty and push when full cannot occur, by construction of the handshakes.
- Output data is driven from the head entry. `out_msg` and `out_rob_index` stay stable while `out_valid & !out_ready`.
- Word contents are not interpreted: reserved fields pass through untouched.

## Timing
- Reset values:
  - `in_ready=1`, `out_valid=0`, `out_msg=0`, `out_rob_index=0`.
  - `err_framing=0`, `err_count=0`, `occupancy=0`.
  - FSM in IDLE, `cnt=0`, FIFO pointers 0.
- Reset asserted mid-message or with a non-empty FIFO discards everything immediately and asynchronously.
- Latency: when the last word is accepted at edge N, `out_valid=1` and the message is visible in the cycle after edge N, if the FIFO was empty.
- Throughput: one word per cycle. With `WORDS=4` and the consumer always ready, this is one message every 4 cycles sustained.
- `err_framing` is registered and high for exactly the cycle after the offending edge.
- `occupancy` is registered and updates at the push/pop edge. `in_ready` is combinational from `occupancy` only.

## Test plan
- Basic assembly, `WORDS=4`:
  - Stimulus: sop word `0x8600_0123`, then `0x1111_1111`, `0x2222_2222`, `0x3333_3333`, with `out_ready=1`.
  - Required: `out_valid` high one cycle after the 4th word; `out_msg=0x8600_0123_1111_1111_2222_2222_3333_3333`; `out_rob_index=0x43`.
- Back-pressure and full FIFO, `DEPTH=4`, `out_ready=0`:
  - Stimulus: 5 back-to-back messages.
  - Required: `in_ready` falls after the 4th message completes (`occupancy=4`); the 5th message's words are held off.
  - Then one pop: `in_ready` returns the next cycle and the 5th message assembles intact.
- Framing errors:
  - Stimulus: a word with `in_sop=0` in IDLE.
  - Required: dropped, 1-cycle `err_framing`, `err_count=1`.
  - Stimulus: a second sop after 2 words of a message.
  - Required: partial discarded, `err_count=2`, and the next 3 words complete a message headed by the second sop.
- Simultaneous push/pop:
  - Stimulus: occupancy 2, with the last word of a message accepted and `out_ready=1` on the same edge.
  - Required: occupancy stays 2 and the FIFO order is preserved across pointer wrap (run 10 messages through `DEPTH=3`).
- Reset mid-operation:
  - Stimulus: assert `reset` asynchronously between edges with 2 words collected and 1 message queued.
  - Required: `out_valid=0` and `occupancy=0` immediately.
  - After release, a fresh 4-word message assembles correctly.
- Parameter sweep:
  - `WORDS=1`: every sop word emerges as a message after one cycle.
  - `WORDS=2`: RRU-to-ROB pair.
  - Check `err_count` saturation by injecting 300 stray words: it holds at 255.

Source files
------------

// File: rtl/packet_assembler_if.sv
// packet_assembler_if: word-serial packet link in, assembled-message stream out
// Link side: in_valid/in_ready/in_sop/in_word. Message side: out_valid/out_ready/out_msg/out_rob_index.
// Status: err_framing pulse, saturating err_count, FIFO occupancy.
interface packet_assembler_if #(
  parameter int WORD_W = 32,
  parameter int WORDS = 4,
  parameter int DEPTH = 4,
  parameter int ROB_IDX_W = 7
);
  logic in_valid, in_ready, in_sop;
  logic [WORD_W-1:0] in_word;
  logic out_valid, out_ready;
  logic [WORDS*WORD_W-1:0] out_msg;
  logic [ROB_IDX_W-1:0] out_rob_index;
  logic err_framing;
  logic [7:0] err_count;
  logic [$clog2(DEPTH+1)-1:0] occupancy;
  modport master (
    output in_valid, in_sop, in_word, out_ready,
    input in_ready, out_valid, out_msg, out_rob_index, err_framing, err_count, occupancy
  );
  modport slave (
    input in_valid, in_sop, in_word, out_ready,
    output in_ready, out_valid, out_msg, out_rob_index, err_framing, err_count, occupancy
  );
endinterface

// File: rtl/packet_assembler.sv
// packet_assembler: frames WORDS-word link packets into messages and queues them in a DEPTH-entry FIFO
// Ports: clk; reset (async, active-high); bus (slave modport) carries the word link, the message
// output with its ROB index, the framing-error pulse/counter and the FIFO occupancy.
module packet_assembler #(
  parameter int WORD_W = 32,
  parameter int WORDS = 4,
  parameter int DEPTH = 4,
  parameter int ROB_IDX_W = 7
) (
  input logic clk,
  input logic reset,
  packet_assembler_if.slave bus
);
  localparam int MSG_W = WORDS * WORD_W;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int PTR_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CNT_W = WORDS > 1 ? $clog2(WORDS) : 1;
  localparam int SLOTS = WORDS > 1 ? WORDS - 1 : 1;
  typedef enum logic {IDLE, COLLECT} state_t;
  state_t state, nextState;
  logic [CNT_W-1:0] cnt, nextCnt, slotIdx;
  logic [WORD_W-1:0] slots [SLOTS];
  logic [MSG_W-1:0] fifo [DEPTH];
  logic [MSG_W-1:0] pushMsg, headMsg;
  logic [PTR_W-1:0] wrPtr, rdPtr;
  logic [OCC_W-1:0] occ;
  logic accept, push, pop, store, frameErr, errFraming;
  logic [7:0] errCount;
  assign accept = bus.in_valid & bus.in_ready;
  assign pop = bus.out_valid & bus.out_ready;
  assign slotIdx = bus.in_sop ? '0 : cnt;
  // The final word is never stored: it goes straight into the pushed message.
  assign store = accept & (bus.in_sop | state == COLLECT) & !push;
  for (genvar i = 0; i < WORDS - 1; i++) begin : g_slot
    assign pushMsg[MSG_W-1-i*WORD_W -: WORD_W] = slots[i];
  end
  assign pushMsg[WORD_W-1:0] = bus.in_word;
  always_comb begin
    nextState = state;
    nextCnt = cnt;
    push = 1'b0;
    frameErr = 1'b0;
    if (accept) begin
      if (bus.in_sop) begin
        frameErr = state == COLLECT;
        push = WORDS == 1;
        nextState = WORDS == 1 ? IDLE : COLLECT;
        nextCnt = WORDS == 1 ? '0 : CNT_W'(1);
      end else if (state == IDLE) begin
        frameErr = 1'b1;
      end else begin
        push = cnt == CNT_W'(WORDS - 1);
        nextState = push ? IDLE : COLLECT;
        nextCnt = push ? '0 : cnt + 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      wrPtr <= '0;
      rdPtr <= '0;
      occ <= '0;
      errFraming <= 1'b0;
      errCount <= '0;
    end else begin
      state <= nextState;
      cnt <= nextCnt;
      if (push) wrPtr <= wrPtr == PTR_W'(DEPTH - 1) ? '0 : wrPtr + 1'b1;
      if (pop) rdPtr <= rdPtr == PTR_W'(DEPTH - 1) ? '0 : rdPtr + 1'b1;
      occ <= occ + OCC_W'(push) - OCC_W'(pop);
      errFraming <= frameErr;
      if (frameErr && errCount != 8'hFF) errCount <= errCount + 8'd1;
    end
  always_ff @(posedge clk) begin
    if (store) slots[slotIdx] <= bus.in_word;
    if (push) fifo[wrPtr] <= pushMsg;
  end
  // Empty FIFO shows zeros so the reset value of out_msg is defined without clearing storage.
  assign headMsg = occ != '0 ? fifo[rdPtr] : '0;
  assign bus.in_ready = occ < OCC_W'(DEPTH);
  assign bus.out_valid = occ != '0;
  assign bus.out_msg = headMsg;
  assign bus.out_rob_index = headMsg[MSG_W-1 -: ROB_IDX_W];
  assign bus.err_framing = errFraming;
  assign bus.err_count = errCount;
  assign bus.occupancy = occ;
endmodule

// File: tb/tb_packet_assembler.sv
// tb_packet_assembler: directed table and sequence checks over four parameter sets of packet_assembler
module tb_packet_assembler;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] inValid = '0;
  logic [3:0] outReady = '0;
  logic inSop = 1'b0;
  logic [31:0] inWord = '0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;

  packet_assembler_if #(.WORD_W(32), .WORDS(4), .DEPTH(4), .ROB_IDX_W(7)) ifA ();
  packet_assembler_if #(.WORD_W(32), .WORDS(4), .DEPTH(3), .ROB_IDX_W(7)) ifB ();
  packet_assembler_if #(.WORD_W(32), .WORDS(1), .DEPTH(2), .ROB_IDX_W(7)) ifC ();
  packet_assembler_if #(.WORD_W(32), .WORDS(2), .DEPTH(2), .ROB_IDX_W(7)) ifD ();
  packet_assembler #(.WORD_W(32), .WORDS(4), .DEPTH(4), .ROB_IDX_W(7)) dutA (.clk(clk), .reset(reset), .bus(ifA));
  packet_assembler #(.WORD_W(32), .WORDS(4), .DEPTH(3), .ROB_IDX_W(7)) dutB (.clk(clk), .reset(reset), .bus(ifB));
  packet_assembler #(.WORD_W(32), .WORDS(1), .DEPTH(2), .ROB_IDX_W(7)) dutC (.clk(clk), .reset(reset), .bus(ifC));
  packet_assembler #(.WORD_W(32), .WORDS(2), .DEPTH(2), .ROB_IDX_W(7)) dutD (.clk(clk), .reset(reset), .bus(ifD));

  logic [3:0] rdy, oValid, err;
  logic [127:0] msg [4];
  logic [6:0] rob [4];
  logic [7:0] errCnt [4];
  logic [2:0] occ [4];

  assign ifA.in_valid = inValid[0]; assign ifA.in_sop = inSop; assign ifA.in_word = inWord; assign ifA.out_ready = outReady[0];
  assign ifB.in_valid = inValid[1]; assign ifB.in_sop = inSop; assign ifB.in_word = inWord; assign ifB.out_ready = outReady[1];
  assign ifC.in_valid = inValid[2]; assign ifC.in_sop = inSop; assign ifC.in_word = inWord; assign ifC.out_ready = outReady[2];
  assign ifD.in_valid = inValid[3]; assign ifD.in_sop = inSop; assign ifD.in_word = inWord; assign ifD.out_ready = outReady[3];
  assign rdy = {ifD.in_ready, ifC.in_ready, ifB.in_ready, ifA.in_ready};
  assign oValid = {ifD.out_valid, ifC.out_valid, ifB.out_valid, ifA.out_valid};
  assign err = {ifD.err_framing, ifC.err_framing, ifB.err_framing, ifA.err_framing};
  assign msg[0] = 128'(ifA.out_msg); assign msg[1] = 128'(ifB.out_msg);
  assign msg[2] = 128'(ifC.out_msg); assign msg[3] = 128'(ifD.out_msg);
  assign rob[0] = ifA.out_rob_index; assign rob[1] = ifB.out_rob_index;
  assign rob[2] = ifC.out_rob_index; assign rob[3] = ifD.out_rob_index;
  assign errCnt[0] = ifA.err_count; assign errCnt[1] = ifB.err_count;
  assign errCnt[2] = ifC.err_count; assign errCnt[3] = ifD.err_count;
  assign occ[0] = 3'(ifA.occupancy); assign occ[1] = 3'(ifB.occupancy);
  assign occ[2] = 3'(ifC.occupancy); assign occ[3] = 3'(ifD.occupancy);

  typedef struct {
    logic v;
    logic sop;
    logic [31:0] w;
    logic ordy;
    logic expValid;
    logic [127:0] expMsg;
    logic expErr;
    logic [7:0] expCnt;
    logic [2:0] expOcc;
  } vec_t;
  vec_t tbl [15];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sendWord(input int k, input logic sop, input logic [31:0] w);
    int n = 0;
    inValid[k] = 1'b1;
    inSop = sop;
    inWord = w;
    while (!rdy[k] && n < 50) begin
      tick();
      n++;
    end
    if (!rdy[k]) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout dut%0d: in_ready stayed 0, expected 1", k);
    end
    tick();
    inValid[k] = 1'b0;
  endtask

  task automatic sendMsg(input int k, input logic [31:0] base, input int n);
    sendWord(k, 1'b1, base);
    for (int j = 1; j < n; j++) sendWord(k, 1'b0, base + 32'(j));
  endtask

  task automatic popCheck(input int k, input string name, input logic [127:0] exp);
    int n = 0;
    while (!oValid[k] && n < 50) begin
      tick();
      n++;
    end
    chk(name, msg[k], exp);
    outReady[k] = 1'b1;
    tick();
    outReady[k] = 1'b0;
  endtask

  function automatic logic [127:0] expMsg4(input logic [31:0] b);
    return {b, b + 32'd1, b + 32'd2, b + 32'd3};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 32'h86000123, 1'b1, 1'b0, 128'h0, 1'b0, 8'd0, 3'd0};
    tbl[1]  = '{1'b1, 1'b0, 32'h11111111, 1'b1, 1'b0, 128'h0, 1'b0, 8'd0, 3'd0};
    tbl[2]  = '{1'b1, 1'b0, 32'h22222222, 1'b1, 1'b0, 128'h0, 1'b0, 8'd0, 3'd0};
    tbl[3]  = '{1'b1, 1'b0, 32'h33333333, 1'b1, 1'b1, 128'h86000123_11111111_22222222_33333333, 1'b0, 8'd0, 3'd1};
    tbl[4]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 128'h0, 1'b0, 8'd0, 3'd0};
    tbl[5]  = '{1'b1, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 128'h0, 1'b1, 8'd1, 3'd0};
    tbl[6]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 128'h0, 1'b0, 8'd1, 3'd0};
    tbl[7]  = '{1'b1, 1'b1, 32'hA0000001, 1'b1, 1'b0, 128'h0, 1'b0, 8'd1, 3'd0};
    tbl[8]  = '{1'b1, 1'b0, 32'hA0000002, 1'b1, 1'b0, 128'h0, 1'b0, 8'd1, 3'd0};
    tbl[9]  = '{1'b1, 1'b1, 32'hB0000001, 1'b1, 1'b0, 128'h0, 1'b1, 8'd2, 3'd0};
    tbl[10] = '{1'b1, 1'b0, 32'hB0000002, 1'b1, 1'b0, 128'h0, 1'b0, 8'd2, 3'd0};
    tbl[11] = '{1'b1, 1'b0, 32'hB0000003, 1'b1, 1'b0, 128'h0, 1'b0, 8'd2, 3'd0};
    tbl[12] = '{1'b1, 1'b0, 32'hB0000004, 1'b0, 1'b1, 128'hB0000001_B0000002_B0000003_B0000004, 1'b0, 8'd2, 3'd1};
    tbl[13] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 128'hB0000001_B0000002_B0000003_B0000004, 1'b0, 8'd2, 3'd1};
    tbl[14] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 128'h0, 1'b0, 8'd2, 3'd0};

    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready", rdy[0], 1'b1);
    chk("reset out_valid", oValid[0], 1'b0);
    chk("reset out_msg", msg[0], 128'h0);
    chk("reset out_rob_index", rob[0], 7'h0);
    chk("reset err_framing", err[0], 1'b0);
    chk("reset err_count", errCnt[0], 8'd0);
    chk("reset occupancy", occ[0], 3'd0);
    chk("reset out_valid others", oValid[3:1], 3'b000);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      inValid[0] = tbl[i].v;
      inSop = tbl[i].sop;
      inWord = tbl[i].w;
      outReady[0] = tbl[i].ordy;
      tick();
      chk($sformatf("vec%0d out_valid", i), oValid[0], tbl[i].expValid);
      if (tbl[i].expValid) begin
        chk($sformatf("vec%0d out_msg", i), msg[0], tbl[i].expMsg);
        chk($sformatf("vec%0d out_rob_index", i), rob[0], tbl[i].expMsg[127:121]);
      end
      chk($sformatf("vec%0d err_framing", i), err[0], tbl[i].expErr);
      chk($sformatf("vec%0d err_count", i), errCnt[0], tbl[i].expCnt);
      chk($sformatf("vec%0d occupancy", i), occ[0], tbl[i].expOcc);
    end
    inValid[0] = 1'b0;
    outReady[0] = 1'b0;

    for (int i = 0; i < 4; i++) sendMsg(0, 32'hC0000000 + 32'(i * 16), 4);
    chk("full occupancy", occ[0], 3'd4);
    chk("full in_ready", rdy[0], 1'b0);
    inValid[0] = 1'b1;
    inSop = 1'b1;
    inWord = 32'hC0000040;
    repeat (3) tick();
    chk("held in_ready", rdy[0], 1'b0);
    chk("held occupancy", occ[0], 3'd4);
    chk("held head stable", msg[0], expMsg4(32'hC0000000));
    outReady[0] = 1'b1;
    tick();
    outReady[0] = 1'b0;
    chk("after pop occupancy", occ[0], 3'd3);
    chk("after pop in_ready", rdy[0], 1'b1);
    sendMsg(0, 32'hC0000040, 4);
    chk("refill occupancy", occ[0], 3'd4);
    for (int i = 1; i < 5; i++) popCheck(0, $sformatf("bp pop%0d", i), expMsg4(32'hC0000000 + 32'(i * 16)));
    chk("drained occupancy", occ[0], 3'd0);

    outReady[1] = 1'b0;
    sendMsg(1, 32'hD0000000, 4);
    sendMsg(1, 32'hD0000010, 4);
    for (int i = 2; i < 10; i++) begin
      sendWord(1, 1'b1, 32'hD0000000 + 32'(i * 16));
      sendWord(1, 1'b0, 32'hD0000001 + 32'(i * 16));
      sendWord(1, 1'b0, 32'hD0000002 + 32'(i * 16));
      chk($sformatf("wrap head%0d", i - 2), msg[1], expMsg4(32'hD0000000 + 32'((i - 2) * 16)));
      outReady[1] = 1'b1;
      sendWord(1, 1'b0, 32'hD0000003 + 32'(i * 16));
      outReady[1] = 1'b0;
      chk($sformatf("wrap occupancy%0d", i), occ[1], 3'd2);
    end
    popCheck(1, "wrap tail8", expMsg4(32'hD0000080));
    popCheck(1, "wrap tail9", expMsg4(32'hD0000090));
    chk("wrap drained", occ[1], 3'd0);

    sendMsg(0, 32'hE0000000, 4);
    sendWord(0, 1'b1, 32'hE0000010);
    sendWord(0, 1'b0, 32'hE0000011);
    #3 reset = 1'b1;
    #1;
    chk("async reset out_valid", oValid[0], 1'b0);
    chk("async reset occupancy", occ[0], 3'd0);
    chk("async reset err_count", errCnt[0], 8'd0);
    chk("async reset in_ready", rdy[0], 1'b1);
    @(posedge clk);
    #3 reset = 1'b0;
    sendMsg(0, 32'hF0000000, 4);
    popCheck(0, "post reset msg", expMsg4(32'hF0000000));
    chk("post reset err_count", errCnt[0], 8'd0);

    outReady[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sendWord(2, 1'b1, 32'h12345670 + 32'(i));
      chk($sformatf("w1 out_valid%0d", i), oValid[2], 1'b1);
      chk($sformatf("w1 out_msg%0d", i), msg[2], 128'(32'h12345670 + 32'(i)));
      chk($sformatf("w1 occupancy%0d", i), occ[2], 3'd1);
    end
    tick();
    chk("w1 drained", oValid[2], 1'b0);
    sendWord(2, 1'b0, 32'h5);
    chk("w1 stray err_framing", err[2], 1'b1);
    chk("w1 stray err_count", errCnt[2], 8'd1);
    outReady[2] = 1'b0;

    sendWord(3, 1'b1, 32'h0AB00000);
    chk("w2 partial out_valid", oValid[3], 1'b0);
    sendWord(3, 1'b0, 32'h00000055);
    chk("w2 out_valid", oValid[3], 1'b1);
    chk("w2 out_msg", msg[3], 128'h0AB00000_00000055);
    chk("w2 out_rob_index", rob[3], 7'h05);
    outReady[3] = 1'b1;
    tick();
    outReady[3] = 1'b0;
    chk("w2 drained", oValid[3], 1'b0);

    inValid[3] = 1'b1;
    inSop = 1'b0;
    inWord = 32'h0;
    repeat (300) tick();
    inValid[3] = 1'b0;
    chk("sat err_count", errCnt[3], 8'd255);
    chk("sat err_framing still pulsing", err[3], 1'b1);
    tick();
    chk("sat err_framing cleared", err[3], 1'b0);
    chk("sat err_count held", errCnt[3], 8'd255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
